// File: rtl/gclk_scan_ctrl.sv
// Scan-line sequencer on the grayscale clock: gates a GCLK burst per row, inserts
// blanked dead time between rows, frames with vsync and drops to IDLE on abort.
module gclk_scan_ctrl #(
  parameter int unsigned GCLK_PER_LINE = 513,
  parameter int unsigned DEAD_CYC      = 8,
  parameter int unsigned SCAN_N        = 16,
  parameter int unsigned ROW_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gclkout_start,
  input  logic             blank,
  input  logic             ovp,
  input  logic             vsync,
  output logic             gclk_en,
  output logic [ROW_W-1:0] row_addr,
  output logic             row_oe_n,
  output logic             line_sw,
  output logic             frame_start,
  output logic             busy
);

  localparam int unsigned CNT_MAX = (GCLK_PER_LINE > DEAD_CYC) ? GCLK_PER_LINE : DEAD_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] GCLK_LAST = CNT_W'(GCLK_PER_LINE - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYC - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(SCAN_N - 1);

  typedef enum logic [1:0] {IDLE, GCLK, DEAD, WAIT_VS} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [ROW_W-1:0] row_nxt;
  logic             vs_pend, vs_pend_nxt;
  logic             abort;
  logic             gclk_en_nxt, row_oe_n_nxt, line_sw_nxt, frame_start_nxt, busy_nxt;

  assign abort = ovp | blank | ~gclkout_start;

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      row_addr    <= '0;
      vs_pend     <= 1'b0;
      gclk_en     <= 1'b0;
      row_oe_n    <= 1'b1;
      line_sw     <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      row_addr    <= row_nxt;
      vs_pend     <= vs_pend_nxt;
      gclk_en     <= gclk_en_nxt;
      row_oe_n    <= row_oe_n_nxt;
      line_sw     <= line_sw_nxt;
      frame_start <= frame_start_nxt;
      busy        <= busy_nxt;
    end
  end

  // Next state; abort dominates every transition
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    row_nxt     = row_addr;
    vs_pend_nxt = vs_pend;
    if (abort) begin
      state_nxt   = IDLE;
      cnt_nxt     = '0;
      row_nxt     = '0;
      vs_pend_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt_nxt     = '0;
          row_nxt     = '0;
          vs_pend_nxt = 1'b0;
          if (vsync) state_nxt = GCLK;
        end
        GCLK: begin
          vs_pend_nxt = vs_pend | vsync;
          if (cnt == GCLK_LAST) begin
            cnt_nxt   = '0;
            state_nxt = DEAD;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        DEAD: begin
          if (cnt != DEAD_LAST) begin
            cnt_nxt     = cnt + CNT_W'(1);
            vs_pend_nxt = vs_pend | vsync;
          end else if (row_addr != ROW_LAST) begin
            cnt_nxt     = '0;
            row_nxt     = row_addr + ROW_W'(1);
            vs_pend_nxt = vs_pend | vsync;
            state_nxt   = GCLK;
          end else begin
            // A vsync landing on this very cycle is deliberately not captured
            cnt_nxt     = '0;
            row_nxt     = '0;
            vs_pend_nxt = 1'b0;
            state_nxt   = vs_pend ? GCLK : WAIT_VS;
          end
        end
        WAIT_VS: begin
          cnt_nxt     = '0;
          row_nxt     = '0;
          vs_pend_nxt = 1'b0;
          if (vsync) state_nxt = GCLK;
        end
        default: begin
          state_nxt   = IDLE;
          cnt_nxt     = '0;
          row_nxt     = '0;
          vs_pend_nxt = 1'b0;
        end
      endcase
    end
  end

  // Output values for the next cycle, derived from the upcoming state
  always_comb begin
    gclk_en_nxt     = 1'b0;
    row_oe_n_nxt    = 1'b1;
    line_sw_nxt     = 1'b0;
    frame_start_nxt = 1'b0;
    busy_nxt        = 1'b0;
    if (state_nxt != IDLE) busy_nxt = 1'b1;
    if (state_nxt == GCLK) begin
      gclk_en_nxt  = 1'b1;
      row_oe_n_nxt = 1'b0;
      // Entering GCLK at row 0 from anywhere else is always a frame start
      frame_start_nxt = (state != GCLK) && (row_nxt == '0);
    end
    if (state_nxt == DEAD && state == GCLK) line_sw_nxt = 1'b1;
  end

endmodule
